// File: rtl/vde_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vde_pkg
// Description : Shared constants and types for the video display engine tile
//               path: map geometry defaults, tile height, datapath widths and
//               the tile scheduler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package vde_pkg;

    // Default map geometry (tiles); the visible frame is 640x480 with 8x8 tiles
    localparam int MAP_WIDTH_DEF  = 80;
    localparam int MAP_HEIGHT_DEF = 60;

    localparam int TILE_H       = 8;
    localparam int SPRITE_IDX_W = 9;
    localparam int MAP_ADDR_W   = 13;
    localparam int CX_W         = 7;   // holds 0..MAP_WIDTH-1
    localparam int LINE_W       = 9;   // holds 0..MAP_HEIGHT*TILE_H
    localparam int ROW_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DATA  = 2'd2,
        ST_OFFER = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/vde_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : vde_tile_scheduler
// Description : Walks one tile-map row per scanline request, fetching each
//               sprite index from map memory and offering
//               {sprite index, row-within-tile} to the sprite emitter over a
//               valid/ready handshake. Tracks scanline / tile-row position
//               across the frame and flags requests that arrive while busy.
//
// Ports       : clk_i          clock
//               rstn_i         asynchronous active-low reset
//               frame_start    frame start pulse (highest priority)
//               line_start_i   scanline request pulse
//               map_addr_o     map memory read address (map_base + cx)
//               map_rd_o       map read strobe
//               map_data_i     sprite index, valid 1 cycle after map_rd_o
//               sprite_valid_o sprite offer to emitter
//               sprite_ready_i emitter accepts offer
//               sprite_data_o  offered sprite index
//               sprite_row_o   {1'b0, line[2:0]}
//               line_done_o    pulse on handshake of last sprite of a line
//               frame_done_o   level, all scanlines of the frame issued
//               overrun_o      sticky, scanline requested while busy
//
// Revision    : 1.0 - initial release
// ============================================================================
module vde_tile_scheduler
    import vde_pkg::*;
#(
    parameter int MAP_WIDTH  = MAP_WIDTH_DEF,
    parameter int MAP_HEIGHT = MAP_HEIGHT_DEF
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    frame_start,
    input  logic                    line_start_i,
    output logic [MAP_ADDR_W-1:0]   map_addr_o,
    output logic                    map_rd_o,
    input  logic [SPRITE_IDX_W-1:0] map_data_i,
    output logic                    sprite_valid_o,
    input  logic                    sprite_ready_i,
    output logic [SPRITE_IDX_W-1:0] sprite_data_o,
    output logic [ROW_W-1:0]        sprite_row_o,
    output logic                    line_done_o,
    output logic                    frame_done_o,
    output logic                    overrun_o
);

    localparam logic [CX_W-1:0]       c_LAST_CX   = CX_W'(MAP_WIDTH - 1);
    localparam logic [MAP_ADDR_W-1:0] c_MAP_STEP  = MAP_ADDR_W'(MAP_WIDTH);
    localparam logic [LINE_W-1:0]     c_NUM_LINES = LINE_W'(MAP_HEIGHT * TILE_H);

    sched_state_t             r_state;
    logic [LINE_W-1:0]        r_line;
    logic [CX_W-1:0]          r_cx;
    logic [MAP_ADDR_W-1:0]    r_map_base;
    logic                     r_map_rd;
    logic                     r_valid;
    logic [SPRITE_IDX_W-1:0]  r_sprite_data;
    logic                     r_frame_done;
    logic                     r_overrun;
    logic                     w_last_accept;

    // Handshake on the final column of the row closes the scanline
    assign w_last_accept = r_valid && sprite_ready_i && (r_cx == c_LAST_CX);

    assign map_addr_o     = r_map_base + MAP_ADDR_W'(r_cx);
    assign map_rd_o       = r_map_rd;
    assign sprite_valid_o = r_valid;
    assign sprite_data_o  = r_sprite_data;
    assign sprite_row_o   = {1'b0, r_line[2:0]};
    assign line_done_o    = w_last_accept;
    assign frame_done_o   = r_frame_done;
    assign overrun_o      = r_overrun;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state       <= ST_IDLE;
            r_line        <= '0;
            r_cx          <= '0;
            r_map_base    <= '0;
            r_map_rd      <= 1'b0;
            r_valid       <= 1'b0;
            r_sprite_data <= '0;
            r_frame_done  <= 1'b0;
            r_overrun     <= 1'b0;
        end else if (frame_start) begin
            // Any offer in flight is dropped; a coincident line request is
            // treated as the first line of the new frame, not as an overrun.
            r_line       <= '0;
            r_cx         <= '0;
            r_map_base   <= '0;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            if (line_start_i) begin
                r_map_rd <= 1'b1;
                r_state  <= ST_ADDR;
            end else begin
                r_map_rd <= 1'b0;
                r_state  <= ST_IDLE;
            end
        end else begin
            r_map_rd <= 1'b0;
            if (line_start_i && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    // Requests after the last line of the frame are ignored
                    if (line_start_i && !r_frame_done) begin
                        r_cx     <= '0;
                        r_map_rd <= 1'b1;
                        r_state  <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    r_state <= ST_DATA;
                end
                ST_DATA: begin
                    r_sprite_data <= map_data_i;
                    r_valid       <= 1'b1;
                    r_state       <= ST_OFFER;
                end
                ST_OFFER: begin
                    if (sprite_ready_i) begin
                        r_valid <= 1'b0;
                        if (r_cx != c_LAST_CX) begin
                            r_cx     <= r_cx + 1'b1;
                            r_map_rd <= 1'b1;
                            r_state  <= ST_ADDR;
                        end else begin
                            r_line <= r_line + 1'b1;
                            // Leaving the bottom row of a tile: advance the
                            // map base by one tile row instead of multiplying.
                            if (r_line[2:0] == 3'd7) begin
                                r_map_base <= r_map_base + c_MAP_STEP;
                            end
                            if ((r_line + 1'b1) == c_NUM_LINES) begin
                                r_frame_done <= 1'b1;
                            end
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/vde_tile_scheduler.md
# vde_tile_scheduler

Sequences the sprite emitter across the visible frame. Once per scanline, on request from the video timing generator, it walks one row of the tile map (80 columns), reads each 9-bit sprite index from map memory, and hands `{sprite index, row-within-tile}` to `vde_sprite_emitter` over a valid/ready handshake. It tracks scanline and tile-row position across a 640x480 frame of 8x8 tiles and flags lines requested before the previous line finished.

## Interface
- `MAP_WIDTH`, 80, tiles per map row.
- `MAP_HEIGHT`, 60, tile rows per frame; scanlines per frame = `MAP_HEIGHT*8`.

Ports:
- `clk_i`  in  1  clock.
- `rstn_i`  in  1  reset; asynchronous, active-low.
- `frame_start`  in  1  one-cycle pulse at frame start.
- `line_start_i`  in  1  one-cycle pulse requesting the next scanline's sprites.
- `map_addr_o`  out  13  map memory read address.
- `map_rd_o`  out  1  map read strobe.
- `map_data_i`  in  9  sprite index; valid exactly 1 cycle after the `map_rd_o` cycle.
- `sprite_valid_o`  out  1  sprite offer to emitter.
- `sprite_ready_i`  in  1  emitter accepts.
- `sprite_data_o`  out  9  sprite index.
- `sprite_row_o`  out  4  `{1'b0, line[2:0]}`.
- `line_done_o`  out  1  one-cycle pulse when the 80th sprite of a line is accepted.
- `frame_done_o`  out  1  level; high once all `MAP_HEIGHT*8` lines have been issued.
- `overrun_o`  out  1  sticky; `line_start_i` arrived while busy.

## Operation
- Registers:
  - `line` (0..480, 9 bit).
  - `cx` (0..79).
  - `map_base` (tile row × `MAP_WIDTH`, 13 bit), kept incrementally with no multiplier.
  - `map_addr_o = map_base + cx`.
- FSM states: IDLE, ADDR, DATA, OFFER.
- IDLE: waits for `line_start_i`. If `frame_done_o=0`, set `cx=0` and go to ADDR. If `frame_done_o=1`, ignore the pulse with no overrun.
- ADDR: `map_rd_o=1`, then DATA.
- DATA: register `map_data_i` into `sprite_data_o`, then OFFER.
- OFFER: `sprite_valid_o=1`. `sprite_data_o` and `sprite_row_o` stay stable until `sprite_ready_i`. On handshake:
  - If `cx<MAP_WIDTH-1`: `cx++`, go to ADDR.
  - Otherwise: pulse `line_done_o`, `line++`, go to IDLE. If the old `line[2:0]==7`, also `map_base += MAP_WIDTH`.
- `line_start_i` seen in any state other than IDLE: ignored; sets `overrun_o`.
- `frame_start` has priority over everything. It clears `line`, `cx`, `map_base`, `overrun_o` and `frame_done_o`, and forces IDLE.
  - An offer in flight is dropped: `sprite_valid_o` goes low next cycle with no handshake. This is legal at frame boundaries; the emitter latches only on handshake.
- `frame_start` and `line_start_i` in the same cycle: line 0 starts, as if `frame_start` preceded it, and `overrun_o` stays 0.
- `frame_done_o` goes high when `line` reaches `MAP_HEIGHT*8`.

## Timing
- Reset values: all outputs 0; state IDLE; `line`, `cx`, `map_base` = 0.
- `line_start_i` in cycle N (IDLE):
  - `map_rd_o` in N+1, addr `map_base`.
  - `sprite_valid_o` from N+3.
- With `sprite_ready_i` held high, the minimum sprite period is 3 cycles, so a full line takes ≥240 cycles.
- `line_done_o` is asserted in the handshake cycle of sprite 79. IDLE is reached in the next cycle.
- Address arithmetic is 13-bit unsigned. Max address is `MAP_WIDTH*MAP_HEIGHT-1` = 4799, so no wrap occurs.
- `frame_done_o` is set in the cycle after the final `line_done_o`.
- Asynchronous reset mid-line: all outputs drop immediately. The emitter sees `sprite_valid_o` low.

## Structure
- Shared `vde_pkg` holds:
  - `MAP_WIDTH`/`MAP_HEIGHT` defaults.
  - `TILE_H=8`.
  - `SPRITE_IDX_W=9`, `MAP_ADDR_W=13`.
  - The scheduler state enum.
- Single module; no sub-module is warranted.
- Top level wires `sprite_valid_o`/`sprite_ready_i`/`sprite_data_o`/`sprite_row_o` directly to the emitter's `sprite_valid_i`/`sprite_ready_o`/`sprite_data_i`/`sprite_row_i`.

## Test plan
- Reset, `frame_start`, `line_start_i`, ready always 1, map[i]=i:
  - addresses 0..79 and sprites 0..79 with row 0;
  - `line_done_o` after 240 cycles;
  - `sprite_valid_o` first high 3 cycles after `line_start_i`.
- Issue lines 0..8:
  - line 7 uses base 0, row 7;
  - line 8 uses addresses 80..159, row 0.
- Emitter model with ready high 1 cycle in 4:
  - data/row stable while valid and not ready;
  - exactly 80 handshakes per line;
  - no duplicate or lost index.
- `line_start_i` at sprite 40:
  - `overrun_o`=1, line unaffected;
  - next `frame_start` clears `overrun_o`.
- `frame_start` during OFFER at cx=30, line 100:
  - valid drops next cycle;
  - a following `line_start_i` yields address 0, row 0.
- Run 480 lines:
  - `frame_done_o`=1, last address 4799;
  - a 481st `line_start_i` produces no `map_rd_o` and no overrun.
- Simultaneous `frame_start` + `line_start_i` mid-frame: line 0 starts, `overrun_o`=0.
